// File: rtl/cdc_pkg.sv
// Shared types for the toggle req/ack CDC handshake (tx side now, rx side later).
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    ERROR
  } cdc_tx_state_t;

  localparam logic CDC_ACK_SYNC_RST_VAL = 1'b0;

endpackage

// File: rtl/sync.sv
// Two-flop level synchroniser with a parameterised reset value.
module sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cdc_hs_tx.sv
// Source-domain half of a toggle req/ack CDC handshake with an ack watchdog.
module cdc_hs_tx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  input  logic                  clear_err,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  cdc_tx_state_t r_state, w_state;
  logic                  r_req,  w_req;
  logic [DATA_WIDTH-1:0] r_data, w_data;
  logic                  r_done, w_done;
  logic                  r_err,  w_err;
  logic [CNT_W-1:0]      r_cnt,  w_cnt;
  logic                  w_ack_s;

  sync #(.RST_VAL(CDC_ACK_SYNC_RST_VAL)) u_ack_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .i_d   (xfer_ack),
    .o_q   (w_ack_s)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_req   <= w_req;
      r_data  <= w_data;
      r_done  <= w_done;
      r_err   <= w_err;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_state = r_state;
    w_req   = r_req;
    w_data  = r_data;
    w_done  = 1'b0;
    w_err   = r_err;
    w_cnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (send) begin
          w_data  = data_in;
          w_req   = ~r_req;
          w_cnt   = '0;
          w_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An ack arriving on the watchdog's last cycle still completes normally.
        if (w_ack_s == r_req) begin
          w_state = IDLE;
          w_done  = 1'b1;
        end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
          w_state = ERROR;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ERROR: begin
        // Leave only once the destination has caught up, so req/ack stay in phase.
        if (clear_err && (w_ack_s == r_req)) begin
          w_state = IDLE;
          w_err   = 1'b0;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign ready       = (r_state == IDLE);
  assign busy        = !ready;
  assign done        = r_done;
  assign timeout_err = r_err;
  assign xfer_req    = r_req;
  assign xfer_data   = r_data;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed + randomized bench for cdc_hs_tx against a transaction-level model.
module tb_cdc_hs_tx;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          send = 1'b0;
  logic          clear_err = 1'b0;
  logic          xfer_ack = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready, busy, done, timeout_err, xfer_req;
  logic [DW-1:0] xfer_data;

  int errs = 0;
  int checks = 0;

  // Expected view of the transmitter, advanced per transaction.
  logic          m_req = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ready = 1'b1;
  logic          m_err = 1'b0;

  cdc_hs_tx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .send        (send),
    .data_in     (data_in),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .clear_err   (clear_err),
    .xfer_req    (xfer_req),
    .xfer_data   (xfer_data),
    .xfer_ack    (xfer_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic now_chk(input logic exp_done, input string tag);
    chk({tag, ".ready"}, ready, m_ready);
    chk({tag, ".busy"}, busy, !m_ready);
    chk({tag, ".done"}, done, exp_done);
    chk({tag, ".err"}, timeout_err, m_err);
    chk({tag, ".req"}, xfer_req, m_req);
    chk({tag, ".data"}, xfer_data, m_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic exp_done, input string tag);
    tick();
    now_chk(exp_done, tag);
  endtask

  task automatic idle(input int unsigned n);
    send = 1'b0;
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, "idle");
  endtask

  task automatic accept(input logic [DW-1:0] d, input string tag);
    send    = 1'b1;
    data_in = d;
    m_req   = ~m_req;
    m_data  = d;
    m_ready = 1'b0;
    cyc(1'b0, tag);
  endtask

  // Destination echoes req onto ack dly cycles after the accept edge; done is due 3 edges later.
  task automatic xfer(input logic [DW-1:0] d, input int unsigned dly, input logic junk);
    accept(d, "accept");
    for (int unsigned i = 0; i < dly + 3; i++) begin
      if (i == dly) xfer_ack = m_req;
      send      = junk ? 1'b1 : 1'($urandom_range(1, 0));
      data_in   = junk ? 32'h12345678 : $urandom;
      clear_err = 1'($urandom_range(1, 0));
      if (i == dly + 2) m_ready = 1'b1;
      cyc(i == dly + 2, "wait");
    end
    send      = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    // Asynchronous reset, asserted between clock edges.
    #7 n_rst = 1'b0;
    #1 now_chk(1'b0, "reset");
    tick();
    #2 n_rst = 1'b1;
    idle(2);

    xfer(32'hDEADBEEF, 4, 1'b0);
    idle(2);

    // Back-to-back: second word accepted in the done cycle.
    xfer(32'hA5A5A5A5, 4, 1'b0);
    xfer(32'h5A5A5A5A, 4, 1'b0);
    idle(1);

    // Sends while busy are ignored.
    xfer($urandom, 3, 1'b1);
    idle(1);

    // Watchdog: 8 WAIT_ACK cycles then ERROR.
    accept($urandom, "to_accept");
    send = 1'b0;
    for (int i = 0; i < 7; i++) cyc(1'b0, "to_wait");
    m_err = 1'b1;
    cyc(1'b0, "to_fire");
    clear_err = 1'b1;
    cyc(1'b0, "to_clr_noack");
    cyc(1'b0, "to_clr_noack");
    clear_err = 1'b0;
    xfer_ack  = m_req;
    for (int i = 0; i < 3; i++) cyc(1'b0, "to_late_ack");
    clear_err = 1'b1;
    m_err     = 1'b0;
    m_ready   = 1'b1;
    cyc(1'b0, "to_cleared");
    clear_err = 1'b0;
    idle(2);

    // Ack match coincides with the last watchdog cycle.
    xfer($urandom, 5, 1'b0);
    idle(1);

    // Reset mid-transfer; destination resets jointly.
    accept($urandom, "rst_accept");
    send = 1'b0;
    cyc(1'b0, "rst_wait");
    #2;
    n_rst    = 1'b0;
    xfer_ack = 1'b0;
    m_req    = 1'b0;
    m_data   = '0;
    m_ready  = 1'b1;
    m_err    = 1'b0;
    #1 now_chk(1'b0, "rst_mid");
    #2 n_rst = 1'b1;
    idle(1);
    xfer(32'hCAFEF00D, 2, 1'b0);

    for (int k = 0; k < 10; k++) begin
      xfer($urandom, $urandom_range(5, 0), 1'($urandom_range(1, 0)));
      idle($urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-domain half of a toggle-based req/ack clock-domain-crossing handshake.
- Captures one DATA_WIDTH word on a local valid/ready interface and presents it on xfer_data with xfer_req toggled.
- Waits for the destination's xfer_ack toggle, resynchronised through the existing 2-flop sync block, then frees for the next word.
- Watchdog flags a destination that never acknowledges.

Parameters:
- DATA_WIDTH, 32, width of transferred word.
- TIMEOUT_CYCLES, 1023, WAIT_ACK cycles before timeout; 0 disables watchdog.

Ports:
- clk  input  1  source-domain clock.
- n_rst  input  1  reset, asynchronous, active-low.
- send  input  1  local request; word accepted when send && ready at rising edge.
- data_in  input  DATA_WIDTH  word to transfer, sampled on accept.
- ready  output  1  block idle, can accept.
- busy  output  1  transfer outstanding (WAIT_ACK or ERROR).
- done  output  1  one-cycle pulse, transfer acknowledged.
- timeout_err  output  1  watchdog expired, held until cleared.
- clear_err  input  1  request exit from ERROR.
- xfer_req  output  1  toggle level to destination domain, registered.
- xfer_data  output  DATA_WIDTH  held-stable data to destination, registered.
- xfer_ack  input  1  asynchronous toggle level from destination.

Behaviour:
- Reset:
  - state IDLE; xfer_req=0, xfer_data=0, done=0, timeout_err=0, counter=0, ack synchroniser=0.
  - ready=1, busy=0 (combinational from state).
- ack_s: xfer_ack through sync instance (RST_VAL 0), two-cycle latency. No other path may sample xfer_ack.
- States IDLE, WAIT_ACK, ERROR. ready = (state==IDLE); busy = !ready.
- IDLE: on send: xfer_data<=data_in, xfer_req<=~xfer_req, counter<=0, ->WAIT_ACK. send without ready is ignored everywhere.
- WAIT_ACK:
  - if ack_s==xfer_req: ->IDLE, done<=1 for exactly one cycle.
  - else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: ->ERROR, timeout_err<=1.
  - else counter++.
  - Match wins over timeout in the same cycle.
  - Counter width $clog2(TIMEOUT_CYCLES+1), saturating never needed.
- ERROR:
  - timeout_err=1, xfer_req and xfer_data held.
  - A late ack is absorbed; no done.
  - ->IDLE and timeout_err<=0 only when clear_err==1 AND ack_s==xfer_req; otherwise stay. A dead destination requires reset.
- xfer_data and xfer_req change only on accept in IDLE. xfer_data stays stable from the toggle until done.
- Latency: xfer_req toggles at the accept edge. done rises at the 3rd clk edge after xfer_ack toggles (2 sync + 1 FSM). ready is high in the done cycle.
- Back-to-back: send accepted in the done cycle; next toggle occurs at that edge.
- Reset mid-transfer: immediate return to reset values. The destination is reset jointly by the system; no recovery protocol.
- clear_err outside ERROR has no effect.

Decomposition:
- Package cdc_pkg: enum cdc_tx_state_t {IDLE, WAIT_ACK, ERROR}; shared by the future cdc_hs_rx.
- Sub-module: one existing sync instance, RST_VAL=0, for xfer_ack. FSM, counter and data register stay in this module.

Test Plan:
- Reset: assert n_rst=0 mid-clock → ready=1, busy=0, xfer_req=0, xfer_data=0, done=0, timeout_err=0, asynchronously.
- Single transfer: send=1, data_in=32'hDEADBEEF for one cycle; destination model echoes xfer_req→xfer_ack 4 cycles later → xfer_req 0→1 at accept edge, xfer_data=DEADBEEF held, done high exactly one cycle, 3 edges after ack toggle; ready returns.
- Back-to-back: send held high, data_in A5A5A5A5 then 5A5A5A5A at the done cycle → xfer_req 0→1→0, second word captured in done cycle, two done pulses, no gap cycle.
- Busy ignore: send=1, data_in=12345678 during WAIT_ACK → xfer_data unchanged, xfer_req unchanged, no extra done.
- Timeout: TIMEOUT_CYCLES=8, no ack → timeout_err rises after 8 WAIT_ACK cycles. clear_err=1 without ack → stays ERROR. Toggle ack, then clear_err=1 → IDLE, timeout_err=0, no done pulse.
- Race and reset: ack match on the same cycle counter hits TIMEOUT_CYCLES-1 → done, no error. Reset asserted in WAIT_ACK → all outputs to reset values; the next transfer toggles xfer_req 0→1.
